// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, flag bit
// positions and controller states.
package alu_pkg;

    localparam logic [3:0] OP_AND    = 4'd0;
    localparam logic [3:0] OP_OR     = 4'd1;
    localparam logic [3:0] OP_NOT    = 4'd2;
    localparam logic [3:0] OP_XOR    = 4'd3;
    localparam logic [3:0] OP_ADD    = 4'd4;
    localparam logic [3:0] OP_ADDPLS = 4'd5;
    localparam logic [3:0] OP_SUB    = 4'd6;
    localparam logic [3:0] OP_SUBMNS = 4'd7;
    localparam logic [3:0] OP_SL     = 4'd8;
    localparam logic [3:0] OP_SRL    = 4'd9;
    localparam logic [3:0] OP_SRA    = 4'd10;
    localparam logic [3:0] OP_MUL    = 4'd11;
    localparam logic [3:0] OP_DIVU   = 4'd12;

    localparam int FLAG_CF = 0;
    localparam int FLAG_ZF = 1;
    localparam int FLAG_NF = 2;
    localparam int FLAG_VF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic isMulDiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multi-cycle datapath: shift-add multiply and restoring divide,
// one bit per clock, sharing the same hi/lo working registers.
module seq_alu_muldiv #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_isDiv,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_carry
);

    localparam logic [SHW:0] CNT_MAX = (SHW+1)'(WIDTH);

    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_opnd;
    logic             r_isDiv;
    logic             r_divZero;
    logic             r_active;
    logic [SHW:0]     r_count;

    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH:0]   w_remShift;
    logic [WIDTH-1:0] w_remDiff;
    logic             w_fits;

    assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_remShift = {r_hi, r_lo[WIDTH-1]};
    assign w_fits     = (w_remShift >= {1'b0, r_opnd});
    // When the trial subtraction fits, the difference is below the divisor,
    // so a WIDTH-bit subtraction is exact.
    assign w_remDiff  = w_remShift[WIDTH-1:0] - r_opnd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo      <= '0;
            r_hi      <= '0;
            r_opnd    <= '0;
            r_isDiv   <= 1'b0;
            r_divZero <= 1'b0;
            r_active  <= 1'b0;
            r_count   <= '0;
        end else if (i_start) begin
            r_lo      <= i_a;
            r_hi      <= '0;
            r_opnd    <= i_b;
            r_isDiv   <= i_isDiv;
            r_divZero <= i_isDiv && (i_b == '0);
            r_active  <= 1'b1;
            r_count   <= '0;
        end else if (r_active) begin
            if (r_count != CNT_MAX) begin
                r_count <= r_count + 1'b1;
                if (r_isDiv) begin
                    r_hi <= w_fits ? w_remDiff : w_remShift[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], w_fits};
                end else begin
                    r_hi <= w_mulSum[WIDTH:1];
                    r_lo <= {w_mulSum[0], r_lo[WIDTH-1:1]};
                end
            end else begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_done  = r_active && (r_count == CNT_MAX);
    assign o_lo    = r_lo;
    assign o_hi    = r_hi;
    assign o_carry = r_isDiv ? r_divZero : (r_hi != '0);

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops computed
// inline, MUL/DIVU delegated to the iterative seq_alu_muldiv unit.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] out_hi,
    output logic [3:0]       flags
);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_outHi;
    logic [3:0]       r_flags;

    logic             w_accept;
    logic             w_isMd;
    logic             w_mdDone;
    logic [WIDTH-1:0] w_mdLo;
    logic [WIDTH-1:0] w_mdHi;
    logic             w_mdCarry;

    logic [SHW-1:0]   w_amt;
    logic             w_isSub;
    logic             w_isArith;
    logic             w_cin;
    logic [WIDTH-1:0] w_addB;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_aluRes;

    logic             w_useMd;
    logic             w_capture;
    logic [WIDTH-1:0] w_capRes;
    logic [WIDTH-1:0] w_capHi;
    logic [3:0]       w_capFlags;

    assign w_accept = in_valid && in_ready;
    assign w_isMd   = isMulDiv(opcode);

    seq_alu_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept && w_isMd),
        .i_isDiv (opcode == OP_DIVU),
        .i_a     (operand_a),
        .i_b     (operand_b),
        .o_done  (w_mdDone),
        .o_lo    (w_mdLo),
        .o_hi    (w_mdHi),
        .o_carry (w_mdCarry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_nextState = w_isMd ? ST_BUSY : ST_HOLD;
            ST_BUSY: if (w_mdDone) w_nextState = ST_HOLD;
            ST_HOLD: if (out_ready) begin
                if (w_accept) w_nextState = w_isMd ? ST_BUSY : ST_HOLD;
                else          w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
        out_valid = (r_state == ST_HOLD);
    end

    // Subtraction reuses the adder as A + ~B + cin, so carry-out is "no borrow".
    assign w_amt     = operand_b[SHW-1:0];
    assign w_isSub   = (opcode == OP_SUB) || (opcode == OP_SUBMNS);
    assign w_isArith = (opcode == OP_ADD) || (opcode == OP_ADDPLS) || w_isSub;
    assign w_cin     = (opcode == OP_ADDPLS) || (opcode == OP_SUB);
    assign w_addB    = w_isSub ? ~operand_b : operand_b;
    assign w_sum     = {1'b0, operand_a} + {1'b0, w_addB} + {{WIDTH{1'b0}}, w_cin};
    assign w_ovf     = w_isArith && (operand_a[WIDTH-1] == w_addB[WIDTH-1])
                       && (w_sum[WIDTH-1] != operand_a[WIDTH-1]);

    always_comb begin
        w_aluRes = operand_a & operand_b;
        case (opcode)
            OP_AND:    w_aluRes = operand_a & operand_b;
            OP_OR:     w_aluRes = operand_a | operand_b;
            OP_NOT:    w_aluRes = ~operand_a;
            OP_XOR:    w_aluRes = operand_a ^ operand_b;
            OP_ADD, OP_ADDPLS, OP_SUB, OP_SUBMNS:
                       w_aluRes = w_sum[WIDTH-1:0];
            OP_SL:     w_aluRes = operand_a << w_amt;
            OP_SRL:    w_aluRes = operand_a >> w_amt;
            OP_SRA:    w_aluRes = WIDTH'($signed(operand_a) >>> w_amt);
            default:   w_aluRes = operand_a & operand_b;
        endcase
    end

    assign w_useMd   = (r_state == ST_BUSY);
    assign w_capture = (w_accept && !w_isMd) || (w_useMd && w_mdDone);
    assign w_capRes  = w_useMd ? w_mdLo : w_aluRes;
    assign w_capHi   = w_useMd ? w_mdHi : '0;

    always_comb begin
        w_capFlags          = '0;
        w_capFlags[FLAG_CF] = w_useMd ? w_mdCarry : (w_isArith && w_sum[WIDTH]);
        w_capFlags[FLAG_ZF] = (w_capRes == '0);
        w_capFlags[FLAG_NF] = w_capRes[WIDTH-1];
        w_capFlags[FLAG_VF] = !w_useMd && w_ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_outHi  <= '0;
            r_flags  <= '0;
        end else if (w_capture) begin
            r_result <= w_capRes;
            r_outHi  <= w_capHi;
            r_flags  <= w_capFlags;
        end
    end

    assign result = r_result;
    assign out_hi = r_outHi;
    assign flags  = r_flags;

endmodule
